// File: rtl/retimer_filter_variable_width.sv
// -----------------------------------------------------------------------------
// retimer_filter_variable_width
//
// Purpose:
//   Brings Width independent asynchronous level inputs into the clk domain
//   through a per-bit flop chain of depth Stages. Each bit is then debounced:
//   the filtered output only follows the synchronized value once it has
//   differed from the filtered value for Filter_Count consecutive cycles.
//   Optional edge detection reports 0->1 / 1->0 transitions of the filtered
//   value as one-cycle registered pulses plus a summary flag.
//
// Parameters:
//   Width        (1..64)     number of independent channels
//   Stages       (2..4)      synchronizer depth per channel
//   Filter_Count (1..65535)  consecutive differing cycles needed to update
//
// Ports:
//   clk           in   1      sole clock, rising edge
//   reset_n       in   1      asynchronous assert, active-low reset
//   Async_In      in   Width  asynchronous level inputs
//   Sync_Out      out  Width  last synchronizer stage
//   Filtered_Out  out  Width  debounced copy of Sync_Out
//   Rise_Pulse    out  Width  one-cycle pulse on Filtered_Out 0->1
//   Fall_Pulse    out  Width  one-cycle pulse on Filtered_Out 1->0
//   Any_Change    out  1      registered OR of all pulse bits
//
// Configuration macro:
//   RETIMER_EDGE_DETECT_EN  defined   -> pulse/any-change flops implemented
//                           undefined -> pulse outputs tied to 0, no flops
// -----------------------------------------------------------------------------
module retimer_filter_variable_width #(
  parameter int Width        = 8,
  parameter int Stages       = 2,
  parameter int Filter_Count = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [Width-1:0] Async_In,
  output logic [Width-1:0] Sync_Out,
  output logic [Width-1:0] Filtered_Out,
  output logic [Width-1:0] Rise_Pulse,
  output logic [Width-1:0] Fall_Pulse,
  output logic             Any_Change
);

  // One extra bit beyond clog2 keeps Filter_Count=1 at a legal 1-bit width.
  localparam int               CNT_W    = $clog2(Filter_Count) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(Filter_Count - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [Width-1:0] sync_q [Stages];
  logic [CNT_W-1:0] cnt_q  [Width];
  logic [CNT_W-1:0] cnt_d  [Width];
  logic [Width-1:0] filt_q;
  logic [Width-1:0] filt_d;
  logic [Width-1:0] sync_s;

  assign sync_s       = sync_q[Stages-1];
  assign Sync_Out     = sync_s;
  assign Filtered_Out = filt_q;

  // Synchronizer chain: pure flop-to-flop, no logic between stages.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < Stages; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= Async_In;
      for (int s = 1; s < Stages; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  // Per-bit stability filter: count cycles of disagreement, load on the last one.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < Width; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync_s[i] == filt_q[i]) begin
        // Agreement (including the end of a short excursion) discards progress.
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        filt_d[i] = sync_s[i];
        cnt_d[i]  = '0;
      end else begin
        // Cannot pass CNT_LAST, so the counter never wraps.
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Filter state registers: counters and debounced outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_q <= '0;
      for (int i = 0; i < Width; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      filt_q <= filt_d;
      for (int i = 0; i < Width; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

`ifdef RETIMER_EDGE_DETECT_EN
  logic [Width-1:0] rise_d;
  logic [Width-1:0] fall_d;
  logic             any_d;
  logic [Width-1:0] rise_q;
  logic [Width-1:0] fall_q;
  logic             any_q;

  // Edge decode from the filter's next state so pulses line up with Filtered_Out.
  always_comb begin
    rise_d = filt_d & ~filt_q;
    fall_d = ~filt_d & filt_q;
    any_d  = |(rise_d | fall_d);
  end

  // Pulse registers; reset keeps them low so reset never emits a pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_q <= '0;
      fall_q <= '0;
      any_q  <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
      any_q  <= any_d;
    end
  end

  assign Rise_Pulse = rise_q;
  assign Fall_Pulse = fall_q;
  assign Any_Change = any_q;
`else
  assign Rise_Pulse = {Width{1'b0}};
  assign Fall_Pulse = {Width{1'b0}};
  assign Any_Change = 1'b0;
`endif

endmodule

// File: tb/tb_retimer_filter_variable_width.sv
// -----------------------------------------------------------------------------
// Self-checking bench for retimer_filter_variable_width.
//   dut_a: Width=4, Stages=2, Filter_Count=3
//   dut_b: Width=1, Stages=3, Filter_Count=1
// Expected pulse values are forced to zero when RETIMER_EDGE_DETECT_EN is
// not defined, since the pulse outputs are then constant 0.
// -----------------------------------------------------------------------------
module tb_retimer_filter_variable_width;

  logic       clk;
  logic       reset_n;
  logic [3:0] async_a;
  logic [3:0] sync_a;
  logic [3:0] filt_a;
  logic [3:0] rise_a;
  logic [3:0] fall_a;
  logic       any_a;
  logic [0:0] async_b;
  logic [0:0] sync_b;
  logic [0:0] filt_b;
  logic [0:0] rise_b;
  logic [0:0] fall_b;
  logic       any_b;

  int checks_n = 0;
  int errors_n = 0;

  retimer_filter_variable_width #(
    .Width(4), .Stages(2), .Filter_Count(3)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .Async_In(async_a), .Sync_Out(sync_a),
    .Filtered_Out(filt_a), .Rise_Pulse(rise_a), .Fall_Pulse(fall_a),
    .Any_Change(any_a)
  );

  retimer_filter_variable_width #(
    .Width(1), .Stages(3), .Filter_Count(1)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .Async_In(async_b), .Sync_Out(sync_b),
    .Filtered_Out(filt_b), .Rise_Pulse(rise_b), .Fall_Pulse(fall_b),
    .Any_Change(any_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks_n++;
    if (act !== exp) begin
      errors_n++;
      $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [3:0] e_sync, input logic [3:0] e_filt,
                         input logic [3:0] e_rise, input logic [3:0] e_fall, input logic e_any);
    logic [3:0] r;
    logic [3:0] f;
    logic       a;
    r = e_rise;
    f = e_fall;
    a = e_any;
`ifndef RETIMER_EDGE_DETECT_EN
    r = 4'b0000;
    f = 4'b0000;
    a = 1'b0;
`endif
    check_eq({tag, ".sync"}, 64'(sync_a), 64'(e_sync));
    check_eq({tag, ".filt"}, 64'(filt_a), 64'(e_filt));
    check_eq({tag, ".rise"}, 64'(rise_a), 64'(r));
    check_eq({tag, ".fall"}, 64'(fall_a), 64'(f));
    check_eq({tag, ".any"},  64'(any_a),  64'(a));
  endtask

  task automatic check_b(input string tag, input logic e_sync, input logic e_filt,
                         input logic e_rise, input logic e_fall);
    logic r;
    logic f;
    r = e_rise;
    f = e_fall;
`ifndef RETIMER_EDGE_DETECT_EN
    r = 1'b0;
    f = 1'b0;
`endif
    check_eq({tag, ".sync"}, 64'(sync_b), 64'(e_sync));
    check_eq({tag, ".filt"}, 64'(filt_b), 64'(e_filt));
    check_eq({tag, ".rise"}, 64'(rise_b), 64'(r));
    check_eq({tag, ".fall"}, 64'(fall_b), 64'(f));
    check_eq({tag, ".any"},  64'(any_b),  64'(r | f));
  endtask

  // From a settled state (old everywhere), drive new and check edges 1..6:
  // Sync_Out switches on edge 2, Filtered_Out and the pulses on edge 5.
  task automatic apply_a(input string tag, input logic [3:0] old_v, input logic [3:0] new_v);
    async_a = new_v;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check_a($sformatf("%s.e%0d", tag, k),
              (k >= 2) ? new_v : old_v,
              (k >= 5) ? new_v : old_v,
              (k == 5) ? (new_v & ~old_v) : 4'b0000,
              (k == 5) ? (old_v & ~new_v) : 4'b0000,
              (k == 5) && (new_v != old_v));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b1;
    async_a = 4'b0000;
    async_b = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_a("rst_async", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    check_b("rst_async_b", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check_a("rst_hold", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Release with bit 0 high: sync after 2 edges, filtered + rise after 5.
    reset_n = 1'b1;
    apply_a("t1", 4'b0000, 4'b0001);

    // Two-cycle dip on bit 0: visible on Sync_Out, swallowed by the filter.
    async_a = 4'b0000;
    tick(); check_a("dip.e1", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    tick(); check_a("dip.e2", 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    async_a = 4'b0001;
    tick(); check_a("dip.e3", 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    tick(); check_a("dip.e4", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    tick(); check_a("dip.e5", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    tick(); check_a("dip.e6", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0);

    // Multi-bit simultaneous transitions.
    apply_a("t2", 4'b0001, 4'b0101);
    apply_a("t3", 4'b0101, 4'b1010);

    // Reset mid-count on bit 2 (counter reaches 2 on edge 4).
    async_a = 4'b1110;
    tick(); check_a("mid.e1", 4'b1010, 4'b1010, 4'b0000, 4'b0000, 1'b0);
    tick(); check_a("mid.e2", 4'b1110, 4'b1010, 4'b0000, 4'b0000, 1'b0);
    tick(); check_a("mid.e3", 4'b1110, 4'b1010, 4'b0000, 4'b0000, 1'b0);
    tick(); check_a("mid.e4", 4'b1110, 4'b1010, 4'b0000, 4'b0000, 1'b0);
    reset_n = 1'b0;
    #1;
    check_a("mid.rst", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tick();
    check_a("mid.rst_hold", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    reset_n = 1'b1;
    apply_a("t4", 4'b0000, 4'b1110);
    apply_a("t5", 4'b1110, 4'b0000);

    // Excursion of exactly Filter_Count cycles on bit 3 must pass, then return.
    async_a = 4'b1000;
    tick(); tick(); tick();
    check_a("exact.e3", 4'b1000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    async_a = 4'b0000;
    tick(); check_a("exact.e4", 4'b1000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tick(); check_a("exact.e5", 4'b0000, 4'b1000, 4'b1000, 4'b0000, 1'b1);
    tick(); check_a("exact.e6", 4'b0000, 4'b1000, 4'b0000, 4'b0000, 1'b0);
    tick(); check_a("exact.e7", 4'b0000, 4'b1000, 4'b0000, 4'b0000, 1'b0);
    tick(); check_a("exact.e8", 4'b0000, 4'b0000, 4'b0000, 4'b1000, 1'b1);
    tick(); check_a("exact.e9", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Stages=3, Filter_Count=1: Filtered_Out trails Async_In by 4 edges.
    async_b = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_b($sformatf("b_up.e%0d", k), k >= 3, k >= 4, k == 4, 1'b0);
    end
    async_b = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_b($sformatf("b_dn.e%0d", k), k < 3, k < 4, 1'b0, k == 4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks_n, errors_n);
    $finish;
  end

endmodule

// File: doc/retimer_filter_variable_width.md
RETIMER_FILTER_VARIABLE_WIDTH -- requirements
Module: Retimer_Filter_Variable_Width

Interface
REQ-001 Parameter Width, default 8: number of independent asynchronous input bits; legal range 1..64.
REQ-002 Parameter Stages, default 2: synchronizer flip-flop depth per bit; legal range 2..4.
REQ-003 Parameter Filter_Count, default 4: consecutive stable cycles required before Filtered_Out follows Sync_Out; legal range 1..65535.
REQ-004 clk  input  1  sole clock; every flop is rising-edge triggered.
REQ-005 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Async_In  input  Width  asynchronous level inputs, one per channel.
REQ-007 Sync_Out  output  Width  raw synchronized copy of Async_In, taken from the last synchronizer stage.
REQ-008 Filtered_Out  output  Width  debounced copy of Sync_Out.
REQ-009 Rise_Pulse  output  Width  one-cycle pulse per bit on a 0->1 transition of Filtered_Out.
REQ-010 Fall_Pulse  output  Width  one-cycle pulse per bit on a 1->0 transition of Filtered_Out.
REQ-011 Any_Change  output  1  registered OR of all Rise_Pulse and Fall_Pulse bits.

Function
REQ-012 Each bit shall pass through a chain of Stages flops with no logic between stages; Sync_Out shall be the last stage, so a level held on Async_In across Stages rising edges appears on Sync_Out after exactly Stages edges.
REQ-013 Each bit shall have its own stability counter with width clog2(Filter_Count)+1; channels shall never interact.
REQ-014 Per bit, per edge: if Sync_Out==Filtered_Out, the counter shall clear to 0.
REQ-015 Per bit, per edge: if Sync_Out!=Filtered_Out and counter==Filter_Count-1, Filtered_Out shall load Sync_Out and the counter shall clear to 0.
REQ-016 Per bit, per edge: if Sync_Out!=Filtered_Out otherwise, the counter shall increment by 1 and shall never wrap.
REQ-017 Total latency from a stable Async_In change to Filtered_Out shall be Stages+Filter_Count edges; with Filter_Count=1, Filtered_Out shall trail Sync_Out by exactly one edge.
REQ-018 A Sync_Out excursion shorter than Filter_Count cycles shall leave Filtered_Out unchanged, clear the counter, and produce no pulse.
REQ-019 Rise_Pulse/Fall_Pulse shall be registered, high in exactly the cycle Filtered_Out first shows the new value, and low in all other cycles.
REQ-020 Any_Change shall be registered in the same cycle as the pulses it summarises.
REQ-021 Simultaneous transitions on several bits shall each produce their own pulse in the same cycle, with a single Any_Change cycle.

Reset
REQ-022 reset_n low shall immediately clear all synchronizer flops, counters, Sync_Out, Filtered_Out, Rise_Pulse, Fall_Pulse and Any_Change to 0, independent of clk.
REQ-023 Reset asserted mid-count shall discard partial counts; no pulse shall be generated by reset assertion or deassertion.
REQ-024 After reset_n deasserts with Async_In held at 1, Filtered_Out shall rise, with Rise_Pulse, after Stages+Filter_Count edges.

Configuration
REQ-025 Macro RETIMER_EDGE_DETECT_EN defined: Rise_Pulse, Fall_Pulse and Any_Change shall be implemented per REQ-019..REQ-021.
REQ-026 Macro RETIMER_EDGE_DETECT_EN undefined: Rise_Pulse, Fall_Pulse and Any_Change shall be tied to constant 0, their flops shall be absent, and all other behaviour shall be unchanged.

Verification (Width=4, Stages=2, Filter_Count=3, macro defined unless noted)
REQ-027 Reset release, then Async_In=4'b0001 held -> Sync_Out=0001 after 2 edges; Filtered_Out=0001 and Rise_Pulse=0001 with Any_Change=1 after 5 edges; both pulses low on edge 6.
REQ-028 Bit 0 filtered at 1, Async_In[0]=0 for 2 cycles then back to 1 -> Sync_Out[0] shows the 2-cycle dip, Filtered_Out stays 0001, no Fall_Pulse, Any_Change stays 0.
REQ-029 Async_In from 4'b0101 to 4'b1010 in one cycle -> Rise_Pulse=1010 and Fall_Pulse=0101 in the same single cycle, one Any_Change cycle, Filtered_Out=1010.
REQ-030 reset_n pulsed low while the bit-2 counter equals 2 -> all outputs 0 immediately, no pulse on release, full 5-edge latency repeats.
REQ-031 Filter_Count=1 and Stages=3 -> Filtered_Out trails Async_In by exactly 4 edges.
REQ-032 Macro undefined, rerun REQ-029 stimulus -> pulse outputs constant 0, Filtered_Out identical to REQ-029.
